// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - shared types and sizing helpers for the MIPS run monitor
package mips_dbg_pkg;

  // Run-control states of the monitor
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STALLED = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

  // Width of an occupancy counter that must represent 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // One trace entry packs pc, instruction and alu_result side by side
  function automatic int trace_width(input int data_w);
    return 3 * data_w;
  endfunction

endpackage

// File: rtl/mips_run_monitor_if.sv
// rtl/mips_run_monitor_if.sv - core-side and trace-read signals of the run monitor
interface mips_run_monitor_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
);
  import mips_dbg_pkg::*;

  localparam int COUNT_W = count_width(DEPTH);

  // core side
  logic              core_reset;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] alu_result;

  // trace read port
  logic               rd_en;
  logic               rd_valid;
  logic [DATA_W-1:0]  rd_pc;
  logic [DATA_W-1:0]  rd_instr;
  logic [DATA_W-1:0]  rd_alu;
  logic [COUNT_W-1:0] trace_count;
  logic               overflow;

  // run status
  logic [CNT_W-1:0] cycle_count;
  logic             stalled;
  logic             timeout;
  logic             done;

  // the monitor itself
  modport slave (
    input  pc_out, instruction, alu_result, rd_en,
    output core_reset, rd_valid, rd_pc, rd_instr, rd_alu, trace_count,
           overflow, cycle_count, stalled, timeout, done
  );

  // whoever drives the core signals and drains the trace
  modport master (
    output pc_out, instruction, alu_result, rd_en,
    input  core_reset, rd_valid, rd_pc, rd_instr, rd_alu, trace_count,
           overflow, cycle_count, stalled, timeout, done
  );

endinterface

// File: rtl/mips_run_monitor_trace_fifo.sv
// rtl/mips_run_monitor_trace_fifo.sv - first-word-fall-through trace FIFO
module trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        push,
  input  logic [WIDTH-1:0]                            push_data,
  input  logic                                        pop,
  output logic [WIDTH-1:0]                            head_data,
  output logic                                        full,
  output logic                                        empty,
  output logic [mips_dbg_pkg::count_width(DEPTH)-1:0] count
);
  import mips_dbg_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when a pop frees the head slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is shown as zero while empty so rd_* read 0 after reset
  assign head_data = empty ? '0 : mem[rd_ptr];
  assign count     = count_q;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - core reset sequencing, PC trace capture and halt/timeout detection
module mips_run_monitor #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int RESET_HOLD  = 4,
  parameter int STALL_LIMIT = 8,
  parameter int MAX_CYCLES  = 1000,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               reset,
  mips_run_monitor_if.slave bus
);
  import mips_dbg_pkg::*;

  localparam int TRACE_W = trace_width(DATA_W);
  localparam int COUNT_W = count_width(DEPTH);
  localparam int HOLD_W  = $clog2(RESET_HOLD + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT);

  run_state_e         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               first_cap;
  logic [DATA_W-1:0]  last_pc;
  logic [STALL_W-1:0] stall_cnt;
  logic [CNT_W-1:0]   cycle_count_q;
  logic               core_reset_q;
  logic               stalled_q;
  logic               timeout_q;
  logic               done_q;
  logic               overflow_q;

  logic               pc_changed;
  logic               capture;
  logic               stall_hit;
  logic               time_hit;
  logic               fifo_full;
  logic               fifo_empty;
  logic [TRACE_W-1:0] head;
  logic [COUNT_W-1:0] fifo_count;

  // The forced first capture counts as a PC change so the stall window
  // always starts from a fresh trace entry.
  assign pc_changed = first_cap || (bus.pc_out != last_pc);
  assign capture    = (state == ST_RUN) && pc_changed;
  assign stall_hit  = !pc_changed && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
  assign time_hit   = (cycle_count_q == CNT_W'(MAX_CYCLES - 1));

  trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data ({bus.pc_out, bus.instruction, bus.alu_result}),
    .pop       (bus.rd_en),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Run-control FSM with its counters and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_HOLD;
      hold_cnt      <= '0;
      first_cap     <= 1'b0;
      last_pc       <= '0;
      stall_cnt     <= '0;
      cycle_count_q <= '0;
      core_reset_q  <= 1'b1;
      stalled_q     <= 1'b0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
            state        <= ST_RUN;
            core_reset_q <= 1'b0;
            first_cap    <= 1'b1;
          end
        end
        ST_RUN: begin
          first_cap <= 1'b0;
          last_pc   <= bus.pc_out;
          if (cycle_count_q != {CNT_W{1'b1}}) begin
            cycle_count_q <= cycle_count_q + 1'b1;
          end
          if (pc_changed) begin
            stall_cnt <= '0;
          end else if (!stall_hit) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
          // A halt loop is the more specific diagnosis, so it wins a tie
          if (stall_hit) begin
            state     <= ST_STALLED;
            stalled_q <= 1'b1;
            done_q    <= 1'b1;
          end else if (time_hit) begin
            state     <= ST_TIMEOUT;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  // Sticky flag: a capture arrived with the FIFO full and nothing draining it
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (capture && fifo_full && !bus.rd_en) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.rd_valid    = !fifo_empty;
  assign bus.rd_pc       = head[TRACE_W-1 -: DATA_W];
  assign bus.rd_instr    = head[2*DATA_W-1 -: DATA_W];
  assign bus.rd_alu      = head[DATA_W-1:0];
  assign bus.trace_count = fifo_count;
  assign bus.overflow    = overflow_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.stalled     = stalled_q;
  assign bus.timeout     = timeout_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// tb/tb_mips_run_monitor.sv - bench for mips_run_monitor
module tb_mips_run_monitor;

  localparam int DW    = 32;
  localparam int DP    = 16;
  localparam int HOLD  = 4;
  localparam int SLIM  = 8;
  localparam int MAXC  = 50;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_run_monitor_if #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) bus ();

  mips_run_monitor #(
    .DATA_W(DW), .DEPTH(DP), .RESET_HOLD(HOLD),
    .STALL_LIMIT(SLIM), .MAX_CYCLES(MAXC), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
  } entry_t;

  // reference model: phase 0 hold, 1 run, 2 stalled, 3 timeout
  entry_t      q[$];
  int          m_phase;
  int          m_hold_done;
  int          m_unchanged;
  int          m_cyc;
  bit          m_first;
  logic [31:0] m_last;
  bit          m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] alu, input bit rd);
    entry_t e;
    int     sz;
    bit     popped;
    bit     changed;
    if (rst) begin
      q.delete();
      m_phase = 0; m_hold_done = 0; m_unchanged = 0; m_cyc = 0;
      m_first = 1; m_last = '0; m_ovf = 0;
    end else begin
      sz     = q.size();
      popped = rd && (sz > 0);
      if (popped) void'(q.pop_front());
      if (m_phase == 0) begin
        m_hold_done++;
        if (m_hold_done == HOLD) m_phase = 1;
      end else if (m_phase == 1) begin
        changed = m_first || (pc != m_last);
        if (changed) begin
          if (sz < DP || popped) begin
            e.pc = pc; e.instr = ins; e.alu = alu;
            q.push_back(e);
          end else begin
            m_ovf = 1;
          end
        end
        m_unchanged = changed ? 0 : m_unchanged + 1;
        if (m_cyc < 65535) m_cyc++;
        m_last  = pc;
        m_first = 0;
        if (m_unchanged == SLIM) m_phase = 2;
        else if (m_cyc == MAXC) m_phase = 3;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] hp, hi, ha;
    hp = 0; hi = 0; ha = 0;
    if (q.size() > 0) begin
      hp = q[0].pc; hi = q[0].instr; ha = q[0].alu;
    end
    check("core_reset",  bus.core_reset,  m_phase == 0);
    check("rd_valid",    bus.rd_valid,    q.size() > 0);
    check("rd_pc",       bus.rd_pc,       hp);
    check("rd_instr",    bus.rd_instr,    hi);
    check("rd_alu",      bus.rd_alu,      ha);
    check("trace_count", bus.trace_count, q.size());
    check("overflow",    bus.overflow,    m_ovf);
    check("cycle_count", bus.cycle_count, m_cyc);
    check("stalled",     bus.stalled,     m_phase == 2);
    check("timeout",     bus.timeout,     m_phase == 3);
    check("done",        bus.done,        m_phase >= 2);
  endtask

  task automatic step(input bit rst, input logic [31:0] pc, input bit rd);
    logic [31:0] ins, alu;
    ins = $urandom;
    alu = $urandom;
    reset           = rst;
    bus.pc_out      = pc;
    bus.instruction = ins;
    bus.alu_result  = alu;
    bus.rd_en       = rd;
    @(posedge clk);
    model_step(rst, pc, ins, alu, rd);
    #1;
    compare_all();
  endtask

  task automatic start_run();
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (HOLD) step(0, 0, 0);
  endtask

  initial begin
    int n;
    logic [31:0] pc;

    // hold timing and reset values
    step(1, 0, 0);
    step(1, 0, 0);
    check("reset_core_reset", bus.core_reset, 1'b1);
    check("reset_count", bus.trace_count, 0);
    n = 0;
    while (bus.core_reset && n < 20) begin
      step(0, 0, 0);
      n++;
    end
    check("hold_cycles", n, HOLD);
    step(0, 0, 0);
    check("first_cap_valid", bus.rd_valid, 1'b1);
    check("first_cap_pc", bus.rd_pc, 32'h0);

    // linear trace
    step(0, 32'h4, 0);
    step(0, 32'h8, 0);
    step(0, 32'hC, 0);
    check("linear_count", bus.trace_count, 4);
    for (int i = 0; i < 4; i++) begin
      check("linear_pc", bus.rd_pc, 32'(4 * i));
      step(0, 32'hC, 1);
    end
    check("linear_drained", bus.trace_count, 0);

    // overflow without reads
    start_run();
    for (int i = 0; i < 20; i++) step(0, 32'h100 + 32'(4 * i), 0);
    check("ovf_count", bus.trace_count, DP);
    check("ovf_flag", bus.overflow, 1'b1);
    for (int i = 0; i < DP; i++) begin
      check("ovf_order", bus.rd_pc, 32'h100 + 32'(4 * i));
      step(0, 32'h100 + 32'(4 * 19), 1);
    end

    // continuous reads keep overflow clear
    start_run();
    for (int i = 0; i < 20; i++) step(0, 32'h100 + 32'(4 * i), 1);
    check("no_ovf_flag", bus.overflow, 1'b0);

    // stall detection
    start_run();
    step(0, 32'h10, 0);
    step(0, 32'h14, 0);
    step(0, 32'h18, 0);
    step(0, 32'h20, 0);
    n = 0;
    while (!bus.stalled && n < 20) begin
      step(0, 32'h20, 0);
      n++;
    end
    check("stall_latency", n, SLIM);
    check("stall_done", bus.done, 1'b1);
    check("stall_cycles", bus.cycle_count, 12);
    for (int i = 0; i < 3; i++) step(0, 32'h40 + 32'(4 * i), 0);
    check("stall_frozen", bus.cycle_count, 12);
    check("stall_no_capture", bus.trace_count, 4);

    // cycle budget timeout
    start_run();
    n = 0;
    while (!bus.timeout && n < 100) begin
      step(0, 32'h1000 + 32'(4 * n), bit'($urandom_range(0, 1)));
      n++;
    end
    check("timeout_cycles", bus.cycle_count, MAXC);
    check("timeout_not_stalled", bus.stalled, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 32'h2000 + 32'(4 * i), 0);

    // reset in the middle of a run
    start_run();
    for (int i = 0; i < 5; i++) step(0, 32'h300 + 32'(4 * i), 0);
    check("mid_count_before", bus.trace_count, 5);
    step(1, 32'h400, 0);
    check("mid_count_after", bus.trace_count, 0);
    check("mid_overflow", bus.overflow, 1'b0);
    check("mid_core_reset", bus.core_reset, 1'b1);
    n = 0;
    while (bus.core_reset && n < 20) begin
      step(0, 0, 0);
      n++;
    end
    check("mid_hold_cycles", n, HOLD);

    // randomized runs with repeats, reads and occasional resets
    for (int r = 0; r < 6; r++) begin
      start_run();
      pc = 32'h200;
      for (int c = 0; c < 70; c++) begin
        if ($urandom_range(0, 2) != 0) pc = 32'h200 + 32'(4 * $urandom_range(0, 5));
        step(bit'($urandom_range(0, 59) == 0), pc, bit'($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_run_monitor.md
Name: mips_run_monitor

Overview:
- Synthesizable run-control and trace monitor that sits beside the MIPS core top (single-cycle or multicycle/pipelined).
- Sequences the core's reset with a parametrised hold time and counts cycles.
- Captures a trace entry (pc, instruction, alu_result) on every PC change into an on-chip FIFO that the bench or a debug port can read.
- Flags a stalled PC (halt loop) and a cycle-budget timeout, replacing open-ended free-running simulation.

Parameters:
- DATA_W, 32, width of pc, instruction and alu_result.
- DEPTH, 16, trace FIFO entries; power of two, minimum 2.
- RESET_HOLD, 4, cycles core_reset stays high after the monitor leaves reset; minimum 1.
- STALL_LIMIT, 8, consecutive cycles with an unchanged PC that count as a stall; minimum 2.
- MAX_CYCLES, 1000, run-cycle budget before timeout.
- CNT_W, 16, width of cycle_count; must hold MAX_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- core_reset  out  1  reset driven to the MIPS core
- pc_out  in  DATA_W  core PC
- instruction  in  DATA_W  core fetched instruction
- alu_result  in  DATA_W  core ALU result
- rd_en  in  1  pop one trace entry
- rd_valid  out  1  FIFO non-empty; head entry present on rd_* outputs
- rd_pc  out  DATA_W  head entry pc
- rd_instr  out  DATA_W  head entry instruction
- rd_alu  out  DATA_W  head entry alu_result
- trace_count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: a capture was dropped
- cycle_count  out  CNT_W  cycles spent in RUN
- stalled  out  1  STALLED state
- timeout  out  1  TIMEOUT state
- done  out  1  stalled | timeout

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state HOLD, hold counter 0, core_reset 1, FIFO empty, rd_valid 0, rd_* 0, trace_count 0, overflow 0, cycle_count 0, stalled 0, timeout 0.
- HOLD:
  - core_reset = 1; the hold counter increments each cycle.
  - After RESET_HOLD cycles in HOLD, go to RUN; core_reset drops in the same edge.
  - The first RUN cycle forces a capture (first_cap flag).
- RUN:
  - cycle_count increments each cycle, saturating at all-ones.
  - Capture when first_cap is set or pc_out != last_pc; last_pc is registered every RUN cycle.
  - Stall counter resets to 0 on a PC change and increments otherwise.
  - Stall counter reaching STALL_LIMIT-1 with PC unchanged -> STALLED.
  - cycle_count reaching MAX_CYCLES-1 -> TIMEOUT.
  - If both fire in the same cycle, STALLED wins.
- STALLED / TIMEOUT:
  - Terminal; left only by reset.
  - No captures; cycle_count frozen; core_reset stays 0.
- Capture latency: an entry becomes visible on rd_* the cycle after the capture edge.
- FIFO is first-word-fall-through; rd_* hold the head while rd_valid = 1.
- Push when full:
  - Without a pop in the same cycle, the entry is dropped and overflow is set.
  - With a pop in the same cycle, both occur and trace_count is unchanged.
- Pop: rd_en while empty is ignored. Simultaneous push and pop on an empty FIFO -> the pop is ignored and the push is accepted.
- Reset mid-operation: all state returns to reset values within one edge, FIFO contents are discarded, and core_reset is reasserted.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; full/empty derived from trace_count.

Decomposition:
- Package mips_dbg_pkg:
  - run-state enum (HOLD, RUN, STALLED, TIMEOUT);
  - TRACE_W = 3*DATA_W;
  - a function giving the count width $clog2(DEPTH)+1.
- One sub-module, trace_fifo:
  - parametrised WIDTH and DEPTH, synchronous reset, FWFT;
  - push/pop/full/empty/count ports.
- FSM, counters and capture logic stay in mips_run_monitor.

Test Plan:
- Hold timing: reset high 2 cycles, RESET_HOLD=4 -> core_reset high exactly 4 cycles after reset falls; first capture pc=0x00000000 read back.
- Linear trace: pc_out steps 0x0,0x4,0x8,0xC, one per cycle -> 4 entries popped in order with matching instruction/alu values; trace_count reaches 4 then returns to 0.
- Overflow: DEPTH=16, 20 distinct PCs, no reads -> trace_count=16, overflow=1, the first 16 PCs are retained in order. Repeat with continuous rd_en -> overflow stays 0.
- Stall: pc held at 0x20 from a given cycle, STALL_LIMIT=8 -> stalled=1 and done=1 exactly 8 cycles after the last change; cycle_count then frozen.
- Timeout: MAX_CYCLES=50, PC changing every cycle -> timeout=1 at cycle_count=50, stalled=0, no further captures.
- Mid-run reset: reset pulse while trace_count=5 in RUN -> next cycle trace_count=0, overflow=0, core_reset=1, and the HOLD sequence repeats.
